fpmul_share_ctrl: RTL and testbench
===================================

Name: fpmul_share_ctrl

Overview:
- Arbitrates up to NREQ requesters onto one shared iterative floating-point multiplier core (Booth mantissa multiplier plus exponent/normalise logic).
- Runs a round-robin grant, latches the winning operands and pulses the core load.
- Counts the core's fixed iteration latency, then captures result and flags and returns them to the granted requester over a valid/ready response handshake.
- Sits between the vector/scalar issue ports and the floating-point multiplier core.

Parameters:
- NREQ, 2, number of requesters (2..4).
- CORE_LAT, 26, negedges from the core_load cycle to a stable core result (min 1).

Ports:
- clk  in  1  clock; all state updates on negedge clk, matching the multiplier core.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  32*NREQ  operand A, IEEE-754 single; requester i in bits [32i+31:32i].
- req_b  in  32*NREQ  operand B, same packing.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted by requester rsp_id.
- rsp_id  out  2  index of the requester owning the response.
- rsp_result  out  32  product.
- rsp_flags  out  3  {exception, overflow, underflow}.
- busy  out  1  high in any state other than IDLE.
- core_load  out  1  core load/reset pulse; core latches core_a/core_b.
- core_a  out  32  operand A to core, held stable LOAD through RUN.
- core_b  out  32  operand B to core, held stable LOAD through RUN.
- core_result  in  32  core product.
- core_exception  in  1  core flag.
- core_overflow  in  1  core flag.
- core_underflow  in  1  core flag.

Behaviour:
- States: IDLE, LOAD, RUN, RESP.
- Reset (rst=1 at a negedge):
  - state=IDLE, rr_ptr=0, cnt=0, core_a=core_b=0.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, busy=0.
  - Any in-flight operation is abandoned with no response. core_load=0 while rst is high.
- IDLE arbitration (combinational):
  - Grant g is the first i with req_valid[i]=1, searching from rr_ptr upward, modulo NREQ.
  - req_ready[g]=1 only in IDLE; all req_ready are 0 in other states.
- Accept (IDLE, any req_valid at a negedge):
  - Latch req_a[g] into core_a, req_b[g] into core_b, g into rsp_id.
  - rr_ptr = (g+1) mod NREQ; go to LOAD.
- LOAD (one cycle):
  - core_load=1, cnt=CORE_LAT-1; go to RUN.
- RUN:
  - core_load=0. While cnt!=0, decrement cnt each negedge.
  - When cnt==0: capture core_result and flags into rsp_result/rsp_flags, set rsp_valid=1, go to RESP.
- RESP:
  - Hold rsp_* stable while rsp_ready=0.
  - On a negedge with rsp_ready=1: rsp_valid=0, go to IDLE. No new grant on that same edge.
- Latency:
  - rsp_valid rises CORE_LAT+1 negedges after the accept edge.
  - Minimum issue interval per operation is CORE_LAT+3 negedges.
- Requester rules:
  - A requester must hold req_valid and its operands until req_ready.
  - A req_valid drop before accept is legal and ignored.
- Simultaneous requests: round-robin guarantees each valid requester is served within NREQ grants.
- Requesters with index >= NREQ do not exist; rsp_id upper bits are 0 when NREQ<=2.
- rsp_ready is ignored outside RESP.

Optional Feature:
- Macro: FPMUL_ZERO_BYPASS_EN.
- Defined:
  - At accept, if req_a[g][30:0]==0 or req_b[g][30:0]==0, skip LOAD/RUN.
  - Next negedge: rsp_result=32'h00000000, rsp_flags=0, rsp_valid=1, state=RESP.
  - core_load is not pulsed for that operation. rr_ptr updates normally.
- Undefined: all operations go through the core with full latency.

Test Plan:
- Reset mid-RUN: accept req0 (0x40000000, 0x40400000), assert rst 5 negedges later -> next negedge state IDLE, rsp_valid=0, busy=0, no response ever issued.
- Single op: req0 issues 2.0*3.0 (0x40000000, 0x40400000) with core model, rsp_ready=1 -> rsp_valid rises 27 negedges after accept, rsp_result=0x40C00000, rsp_flags=0, rsp_id=0.
- Contention: req0 and req1 valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; each gets 4 results in order, no starvation.
- Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_result/rsp_id stable, req_ready all 0, no core_load; release -> IDLE next negedge, then new grant.
- Flags: operands 0x7F800000 × 0x3F800000 -> rsp_flags=3'b100, rsp_result=0. Operands 0x7F000000 × 0x7F000000 -> rsp_flags=3'b010, rsp_result=0x7F800000.
- Zero bypass (FPMUL_ZERO_BYPASS_EN defined): req1 issues 0x00000000 × 0x40400000 -> rsp_valid one negedge after accept, result 0, core_load never asserted. Macro undefined -> same result after 27 negedges.

Source files
------------

// File: rtl/fpmul_share_ctrl_if.sv
// Requester/response bus between the issue ports and fpmul_share_ctrl.
// master = issue side, slave = the sharing controller.
interface fpmul_share_ctrl_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [1:0]         rsp_id;
    logic [31:0]        rsp_result;
    logic [2:0]         rsp_flags;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
    );
endinterface

// File: rtl/fpmul_share_ctrl.sv
// Round-robin sharing of one iterative FP multiplier core among NREQ requesters.
// Optional FPMUL_ZERO_BYPASS_EN: zero operands answer 0 without using the core.
module fpmul_share_ctrl #(
    parameter int NREQ     = 2,
    parameter int CORE_LAT = 26
) (
    input  logic              clk,
    input  logic              rst,
    fpmul_share_ctrl_if.slave bus,
    output logic              busy,
    output logic              core_load,
    output logic [31:0]       core_a,
    output logic [31:0]       core_b,
    input  logic [31:0]       core_result,
    input  logic              core_exception,
    input  logic              core_overflow,
    input  logic              core_underflow
);
    localparam int CW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [1:0]    rr_ptr_reg, rr_ptr_next;
    logic [31:0]   core_a_reg, core_a_next;
    logic [31:0]   core_b_reg, core_b_next;
    logic          rsp_valid_reg, rsp_valid_next;
    logic [1:0]    rsp_id_reg, rsp_id_next;
    logic [31:0]   rsp_result_reg, rsp_result_next;
    logic [2:0]    rsp_flags_reg, rsp_flags_next;

    // Requester views padded to four slots so a 2-bit index is always legal.
    logic [3:0]  valid_ext;
    logic [31:0] a_arr [4];
    logic [31:0] b_arr [4];

    assign valid_ext = 4'(bus.req_valid);

    for (genvar gi = 0; gi < 4; gi++) begin : g_opnd
        if (gi < NREQ) begin : g_real
            assign a_arr[gi] = bus.req_a[32*gi +: 32];
            assign b_arr[gi] = bus.req_b[32*gi +: 32];
        end else begin : g_none
            assign a_arr[gi] = '0;
            assign b_arr[gi] = '0;
        end
    end

    // Candidate gi is the requester gi places after rr_ptr; lowest hit wins.
    logic [1:0]      cand_idx [NREQ];
    logic [NREQ-1:0] cand_hit;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        logic [2:0] sum;
        assign sum          = {1'b0, rr_ptr_reg} + 3'(gi);
        assign cand_idx[gi] = (sum >= 3'(NREQ)) ? 2'(sum - 3'(NREQ)) : sum[1:0];
        assign cand_hit[gi] = valid_ext[cand_idx[gi]];
    end

    logic [1:0] grant;
    logic       grant_valid;
    logic [2:0] grant_inc;

    always_comb begin
        grant       = 2'd0;
        grant_valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                grant       = cand_idx[k];
                grant_valid = 1'b1;
            end
        end
    end

    assign grant_inc = {1'b0, grant} + 3'd1;

    logic [NREQ-1:0] ready_vec;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
        assign ready_vec[gi] = (state_reg == IDLE) && grant_valid && (grant == 2'(gi));
    end

    assign bus.req_ready = ready_vec;

`ifdef FPMUL_ZERO_BYPASS_EN
    logic zero_op;
    logic zero_reg, zero_next;
    assign zero_op = (a_arr[grant][30:0] == 31'd0) || (b_arr[grant][30:0] == 31'd0);
`endif

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        rr_ptr_next     = rr_ptr_reg;
        core_a_next     = core_a_reg;
        core_b_next     = core_b_reg;
        rsp_valid_next  = rsp_valid_reg;
        rsp_id_next     = rsp_id_reg;
        rsp_result_next = rsp_result_reg;
        rsp_flags_next  = rsp_flags_reg;
`ifdef FPMUL_ZERO_BYPASS_EN
        zero_next       = zero_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    core_a_next = a_arr[grant];
                    core_b_next = b_arr[grant];
                    rsp_id_next = grant;
                    rr_ptr_next = (grant_inc >= 3'(NREQ)) ? 2'd0 : grant_inc[1:0];
                    state_next  = LOAD;
`ifdef FPMUL_ZERO_BYPASS_EN
                    // A zero product skips the core: RUN with cnt=0 answers next edge.
                    zero_next = zero_op;
                    if (zero_op) begin
                        cnt_next   = '0;
                        state_next = RUN;
                    end
`endif
                end
            end
            LOAD: begin
                cnt_next   = CW'(CORE_LAT - 1);
                state_next = RUN;
            end
            RUN: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CW'(1);
                end else begin
                    rsp_result_next = core_result;
                    rsp_flags_next  = {core_exception, core_overflow, core_underflow};
`ifdef FPMUL_ZERO_BYPASS_EN
                    if (zero_reg) begin
                        rsp_result_next = '0;
                        rsp_flags_next  = '0;
                    end
`endif
                    rsp_valid_next = 1'b1;
                    state_next     = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            rr_ptr_reg     <= 2'd0;
            core_a_reg     <= '0;
            core_b_reg     <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= 2'd0;
            rsp_result_reg <= '0;
            rsp_flags_reg  <= '0;
`ifdef FPMUL_ZERO_BYPASS_EN
            zero_reg       <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            rr_ptr_reg     <= rr_ptr_next;
            core_a_reg     <= core_a_next;
            core_b_reg     <= core_b_next;
            rsp_valid_reg  <= rsp_valid_next;
            rsp_id_reg     <= rsp_id_next;
            rsp_result_reg <= rsp_result_next;
            rsp_flags_reg  <= rsp_flags_next;
`ifdef FPMUL_ZERO_BYPASS_EN
            zero_reg       <= zero_next;
`endif
        end
    end

    assign busy           = (state_reg != IDLE);
    assign core_load      = (state_reg == LOAD) && !rst;
    assign core_a         = core_a_reg;
    assign core_b         = core_b_reg;
    assign bus.rsp_valid  = rsp_valid_reg;
    assign bus.rsp_id     = rsp_id_reg;
    assign bus.rsp_result = rsp_result_reg;
    assign bus.rsp_flags  = rsp_flags_reg;
endmodule

// File: tb/tb_fpmul_share_ctrl.sv
// Scoreboard bench for fpmul_share_ctrl with a table-driven latency model of the core.
module tb_fpmul_share_ctrl;
    localparam int NREQ     = 2;
    localparam int CORE_LAT = 26;
    localparam int NV       = 12;
`ifdef FPMUL_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [2:0]  f;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] r;
        logic [2:0]  f;
        int          acc_edge;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy, core_load;
    logic [31:0] core_a, core_b, core_result;
    logic        core_exception, core_overflow, core_underflow;

    int total = 0;
    int passed = 0;
    int ncnt = 0;
    int acc_cnt0 = 0;
    int acc_cnt1 = 0;
    int exp_loads = 0;
    int seen_loads = 0;
    int last_acc_edge = 0;
    int last_hs_edge = 0;
    int q0[$];
    int q1[$];
    exp_t exq[$];

    always #5 clk = ~clk;

    fpmul_share_ctrl_if #(.NREQ(NREQ)) bus ();

    fpmul_share_ctrl #(.NREQ(NREQ), .CORE_LAT(CORE_LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .busy(busy), .core_load(core_load),
        .core_a(core_a), .core_b(core_b), .core_result(core_result),
        .core_exception(core_exception), .core_overflow(core_overflow),
        .core_underflow(core_underflow)
    );

    // Hand-computed products: {a, b, result, {exception, overflow, underflow}}
    function automatic vec_t vec(input int i);
        case (i)
            0:  return {32'h40000000, 32'h40400000, 32'h40C00000, 3'b000};
            1:  return {32'h7F800000, 32'h3F800000, 32'h00000000, 3'b100};
            2:  return {32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010};
            3:  return {32'h00000000, 32'h40400000, 32'h00000000, 3'b000};
            4:  return {32'h3F800000, 32'h3FC00000, 32'h3FC00000, 3'b000};
            5:  return {32'h40000000, 32'h40000000, 32'h40800000, 3'b000};
            6:  return {32'h40400000, 32'h40400000, 32'h41100000, 3'b000};
            7:  return {32'h3F000000, 32'h40800000, 32'h40000000, 3'b000};
            8:  return {32'h40A00000, 32'h40000000, 32'h41200000, 3'b000};
            9:  return {32'hBF800000, 32'h40000000, 32'hC0000000, 3'b000};
            10: return {32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000};
            default: return {32'h41000000, 32'h3E800000, 32'h40000000, 3'b000};
        endcase
    endfunction

    function automatic vec_t lookup(input logic [31:0] a, input logic [31:0] b);
        vec_t v;
        for (int i = 0; i < NV; i++) begin
            v = vec(i);
            if (v.a == a && v.b == b) return v;
        end
        return {a, b, 32'hDEADBEEF, 3'b111};
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    initial forever begin
        @(negedge clk);
        ncnt++;
    end

    // Core model: garbage until CORE_LAT negedges after the load edge.
    initial begin : core_model
        int   mcnt;
        vec_t v;
        mcnt = 0;
        v = '0;
        core_result = 32'hBAD0BAD0;
        {core_exception, core_overflow, core_underflow} = 3'b111;
        forever begin
            @(negedge clk);
            if (core_load) begin
                v = lookup(core_a, core_b);
                if (CORE_LAT == 1) begin
                    core_result <= v.r;
                    {core_exception, core_overflow, core_underflow} <= v.f;
                end else begin
                    mcnt = CORE_LAT - 1;
                    core_result <= 32'hBAD0BAD0;
                    {core_exception, core_overflow, core_underflow} <= 3'b111;
                end
            end else if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    core_result <= v.r;
                    {core_exception, core_overflow, core_underflow} <= v.f;
                end
            end
        end
    end

    // Requester driver: presents the head of each queue, pops after acceptance.
    initial begin : driver
        int   s0, s1;
        vec_t v;
        s0 = 0;
        s1 = 0;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        forever begin
            @(negedge clk);
            #1;
            if (acc_cnt0 != s0) begin s0 = acc_cnt0; void'(q0.pop_front()); end
            if (acc_cnt1 != s1) begin s1 = acc_cnt1; void'(q1.pop_front()); end
            v = (q0.size() > 0) ? vec(q0[0]) : '0;
            bus.req_valid[0] = (q0.size() > 0);
            bus.req_a[31:0] = v.a;
            bus.req_b[31:0] = v.b;
            v = (q1.size() > 0) ? vec(q1[0]) : '0;
            bus.req_valid[1] = (q1.size() > 0);
            bus.req_a[63:32] = v.a;
            bus.req_b[63:32] = v.b;
        end
    end

    // Accept sampler: checks the grant and pushes the expected response.
    initial begin : sampler
        int   rr_exp, g_exp, idx, vidx;
        bit   zero;
        vec_t v;
        exp_t e;
        rr_exp = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                rr_exp = 0;
                chk(core_load == 1'b0, "core_load_in_rst", 32'(core_load), 0);
            end else begin
                if (core_load) seen_loads++;
                chk($onehot0(bus.req_ready), "ready_onehot", 32'(bus.req_ready), 0);
                for (int i = 0; i < NREQ; i++) begin
                    if (bus.req_valid[i] && bus.req_ready[i]) begin
                        g_exp = -1;
                        for (int k = 0; k < NREQ; k++) begin
                            idx = (rr_exp + k) % NREQ;
                            if (g_exp < 0 && bus.req_valid[idx]) g_exp = idx;
                        end
                        chk(i == g_exp, "grant", 32'(i), 32'(g_exp));
                        vidx = (i == 0) ? q0[0] : q1[0];
                        v = vec(vidx);
                        zero = (v.a[30:0] == 31'd0) || (v.b[30:0] == 31'd0);
                        e.id = i;
                        e.r = (BYP && zero) ? 32'h0 : v.r;
                        e.f = (BYP && zero) ? 3'b000 : v.f;
                        e.acc_edge = ncnt + 1;
                        e.lat = (BYP && zero) ? 1 : CORE_LAT + 1;
                        exq.push_back(e);
                        if (!(BYP && zero)) exp_loads++;
                        last_acc_edge = ncnt + 1;
                        rr_exp = (i + 1) % NREQ;
                        $display("accept req%0d a=%h b=%h at negedge %0d", i, v.a, v.b, ncnt + 1);
                        if (i == 0) acc_cnt0++;
                        else acc_cnt1++;
                    end
                end
            end
        end
    end

    // Response monitor: latency, hold-while-stalled, and content against the scoreboard.
    initial begin : monitor
        bit          pv;
        logic [31:0] pr;
        logic [1:0]  pid;
        logic [2:0]  pf;
        exp_t        e;
        pv = 1'b0;
        pr = '0;
        pid = '0;
        pf = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                exq.delete();
                pv = 1'b0;
            end else begin
                if (bus.rsp_valid) begin
                    chk(bus.req_ready == '0, "ready_in_resp", 32'(bus.req_ready), 0);
                    if (!pv) begin
                        if (exq.size() == 0)
                            chk(1'b0, "unexpected_rsp", bus.rsp_result, 0);
                        else
                            chk(ncnt - exq[0].acc_edge == exq[0].lat, "latency",
                                32'(ncnt - exq[0].acc_edge), 32'(exq[0].lat));
                    end else begin
                        chk(bus.rsp_result == pr && bus.rsp_id == pid && bus.rsp_flags == pf,
                            "rsp_hold", bus.rsp_result, pr);
                    end
                    if (bus.rsp_ready && exq.size() > 0) begin
                        e = exq.pop_front();
                        last_hs_edge = ncnt + 1;
                        $display("rsp id=%0d result=%h flags=%b", bus.rsp_id, bus.rsp_result, bus.rsp_flags);
                        chk(bus.rsp_id == 2'(e.id), "rsp_id", 32'(bus.rsp_id), 32'(e.id));
                        chk(bus.rsp_result == e.r, "rsp_result", bus.rsp_result, e.r);
                        chk(bus.rsp_flags == e.f, "rsp_flags", 32'(bus.rsp_flags), 32'(e.f));
                    end
                end
                pv = bus.rsp_valid;
                pr = bus.rsp_result;
                pid = bus.rsp_id;
                pf = bus.rsp_flags;
            end
        end
    end

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || exq.size() > 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(n < budget, "drain_timeout", 32'(n), 32'(budget));
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n, a0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        chk(busy == 1'b0, "rst_busy", 32'(busy), 0);
        chk(bus.rsp_valid == 1'b0, "rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk(bus.rsp_id == 2'd0, "rst_rsp_id", 32'(bus.rsp_id), 0);
        chk(bus.rsp_result == 32'h0, "rst_rsp_result", bus.rsp_result, 0);
        chk(bus.rsp_flags == 3'd0, "rst_rsp_flags", 32'(bus.rsp_flags), 0);
        chk(core_a == 32'h0 && core_b == 32'h0, "rst_core_ops", core_a, 0);
        @(negedge clk);
        #1 rst = 1'b0;

        // Reset in the middle of RUN: operation dropped, no response.
        a0 = acc_cnt0;
        q0.push_back(0);
        n = 0;
        while (acc_cnt0 == a0 && n < 20) begin @(negedge clk); n++; end
        chk(n < 20, "midrun_accept_timeout", 32'(n), 20);
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        chk(busy == 1'b0, "midrun_rst_busy", 32'(busy), 0);
        chk(bus.rsp_valid == 1'b0, "midrun_rst_valid", 32'(bus.rsp_valid), 0);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (40) @(negedge clk);
        #1;

        // Single operation 2.0 * 3.0.
        q0.push_back(0);
        wait_done(100);

        // Contention: both requesters continuously valid.
        q0.push_back(4); q0.push_back(5); q0.push_back(6); q0.push_back(7);
        q1.push_back(8); q1.push_back(9); q1.push_back(10); q1.push_back(11);
        wait_done(400);

        // Backpressure with a competing request pending; also the flag vectors.
        bus.rsp_ready = 1'b0;
        q1.push_back(1);
        q0.push_back(2);
        n = 0;
        while (!bus.rsp_valid && n < 100) begin @(negedge clk); n++; end
        chk(n < 100, "bp_wait_timeout", 32'(n), 100);
        repeat (10) @(negedge clk);
        #1;
        a0 = acc_cnt0;
        bus.rsp_ready = 1'b1;
        n = 0;
        while (acc_cnt0 == a0 && n < 20) begin @(negedge clk); n++; end
        chk(n < 20, "regrant_timeout", 32'(n), 20);
        chk(last_acc_edge - last_hs_edge == 1, "regrant_gap",
            32'(last_acc_edge - last_hs_edge), 1);
        wait_done(100);

        // Zero operand on requester 1.
        q1.push_back(3);
        wait_done(100);

        chk(seen_loads == exp_loads, "core_load_count", 32'(seen_loads), 32'(exp_loads));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
